tag_ram_ctrl: RTL and testbench

Sequencing and arbitration controller for one simple-dual-port cache tag/valid RAM (1-cycle read latency, write port A, read port B). After reset, and on every flush request, it sweeps the whole array to zero. Outside sweeps it shares the single write port between a high-priority refill writer and a low-priority invalidate writer, with a starvation guard. It passes reads through and tracks read-data validity.

---
 rtl/tag_ram_ctrl_if.sv | 42 ++++
 rtl/tag_ram_ctrl.sv | 141 ++++++++++++++
 tb/tb_tag_ram_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_ram_ctrl_if.sv
// Requester-side bus of the tag/valid RAM controller.
// Carries the refill write, invalidate, flush and read channels.
// master: the cache logic issuing requests.
// slave : tag_ram_ctrl, which returns acks, status and read validity.
interface tag_ram_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);

  // Refill write channel
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;

  // Invalidate channel (writes all-zero data)
  logic                  inv_req;
  logic [ADDR_WIDTH-1:0] inv_addr;
  logic                  inv_ack;

  // Flush and sweep status
  logic                  flush_req;
  logic                  flush_done;
  logic                  busy;

  // Read channel
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ready;
  logic                  rd_valid;

  modport master (
    output wr_req, wr_addr, wr_data, inv_req, inv_addr, flush_req, rd_en, rd_addr,
    input  wr_ack, inv_ack, flush_done, busy, rd_ready, rd_valid
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, inv_req, inv_addr, flush_req, rd_en, rd_addr,
    output wr_ack, inv_ack, flush_done, busy, rd_ready, rd_valid
  );

endinterface

// File: rtl/tag_ram_ctrl.sv
// Sequencing and arbitration controller for a simple-dual-port cache
// tag/valid RAM (port A write, port B read, 1-cycle read latency).
// Zeroes the whole array after reset and on each flush request, arbitrates
// the write port between refill (high priority) and invalidate (low
// priority, with a starvation guard), and passes reads through.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   bus (slave)        requester channels: refill write, invalidate, flush,
//                      read, with wr_ack/inv_ack/flush_done/busy/rd_ready/
//                      rd_valid returned
//   ram_ena/ram_wea    port A enable / write enable (always equal)
//   ram_addra/dina     port A address / write data
//   ram_enb/ram_addrb  port B read enable / address
module tag_ram_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SIZE         = 64,
  parameter int unsigned ADDR_WIDTH   = $clog2(SIZE),
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  tag_ram_ctrl_if.slave         bus,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb
);

  localparam int unsigned SWEEP_W  = ADDR_WIDTH + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e                state_q;
  logic [SWEEP_W-1:0]    sweep_addr_q;
  logic                  flush_pend_q;
  logic [STARVE_W-1:0]   starve_cnt_q;
  logic                  rd_valid_q;
  logic                  flush_done_q;

  logic                  sweeping;
  logic                  idle;
  logic                  sweep_last;
  logic                  starved;
  logic                  inv_win;
  logic                  wr_win;

  // Sweep / arbitration decode
  assign sweeping   = (state_q != S_IDLE);
  assign idle       = (state_q == S_IDLE);
  assign sweep_last = (sweep_addr_q == SWEEP_W'(SIZE - 1));
  assign starved    = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));

  // Invalidate only wins when refill is absent or it has been starved long enough
  assign inv_win = idle && bus.inv_req && (!bus.wr_req || starved);
  assign wr_win  = idle && bus.wr_req && !inv_win;

  // Status and handshake outputs
  assign bus.wr_ack     = wr_win;
  assign bus.inv_ack    = inv_win;
  assign bus.busy       = sweeping;
  assign bus.rd_ready   = !sweeping;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.flush_done = flush_done_q;

  // Read port passes straight through while not sweeping
  assign ram_enb   = bus.rd_en && !sweeping;
  assign ram_addrb = bus.rd_addr;

  // Write port mux: sweep, then invalidate, then refill
  always_comb begin
    ram_wea   = sweeping || wr_win || inv_win;
    ram_ena   = ram_wea;
    ram_addra = bus.wr_addr;
    ram_dina  = bus.wr_data;
    if (sweeping) begin
      ram_addra = sweep_addr_q[ADDR_WIDTH-1:0];
      ram_dina  = '0;
    end else if (inv_win) begin
      ram_addra = bus.inv_addr;
      ram_dina  = '0;
    end
  end

  // Controller state, sweep counter, flush merge, starvation counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_INIT;
      sweep_addr_q <= '0;
      flush_pend_q <= 1'b0;
      starve_cnt_q <= '0;
      rd_valid_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      rd_valid_q   <= bus.rd_en && !sweeping;
      flush_done_q <= 1'b0;

      // Saturating count of denied invalidate cycles while idle
      if (!bus.inv_req || inv_win) begin
        starve_cnt_q <= '0;
      end else if (idle && !starved) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.flush_req) begin
            state_q      <= S_FLUSH;
            sweep_addr_q <= '0;
          end
        end
        S_INIT, S_FLUSH: begin
          if (sweep_last) begin
            // A request arriving in the last sweep cycle merges into the pending flush
            sweep_addr_q <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= (state_q == S_FLUSH);
            state_q      <= (flush_pend_q || bus.flush_req) ? S_FLUSH : S_IDLE;
          end else begin
            sweep_addr_q <= sweep_addr_q + 1'b1;
            if (bus.flush_req) begin
              flush_pend_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= S_INIT;
          sweep_addr_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Directed bench for tag_ram_ctrl with a behavioural 1-cycle-latency
// simple-dual-port RAM attached to the RAM ports.
module tb_tag_ram_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned SZ = 64;
  localparam int unsigned AW = 6;
  localparam int unsigned SL = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina;
  logic [DW-1:0] ram_doutb;
  logic [DW-1:0] mem [SZ];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tag_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  tag_ram_ctrl #(
    .DATA_WIDTH  (DW),
    .SIZE        (SZ),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .ram_ena  (ram_ena),
    .ram_wea  (ram_wea),
    .ram_addra(ram_addra),
    .ram_dina (ram_dina),
    .ram_enb  (ram_enb),
    .ram_addrb(ram_addrb)
  );

  // RAM model: write-first on a same-address collision
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= (ram_ena && ram_wea && ram_addra == ram_addrb) ? ram_dina : mem[ram_addrb];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.inv_req   = 1'b0;
    bus.inv_addr  = '0;
    bus.flush_req = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt, done_cnt, done_at, first_idle;
    logic found;
    logic [AW-1:0] first_addr;

    quiet_inputs();
    resetn = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_busy", bus.busy, 1);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_flush_done", bus.flush_done, 0);
    chk("rst_rd_ready", bus.rd_ready, 0);

    // Init sweep with a refill and a read held pending
    next_cycle();
    resetn      = 1'b1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 6'h12;
    bus.wr_data = 32'hA5A5_A5A5;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 6'h00;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      chk("init_busy", bus.busy, 1);
      chk("init_addra", ram_addra, c);
      chk("init_dina", ram_dina, 0);
      chk("init_wea", ram_wea, 1);
      chk("init_ena", ram_ena, 1);
      chk("init_wr_ack", bus.wr_ack, 0);
      chk("init_inv_ack", bus.inv_ack, 0);
      chk("init_enb", ram_enb, 0);
      chk("init_rd_ready", bus.rd_ready, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("c64_busy", bus.busy, 0);
    chk("c64_wr_ack", bus.wr_ack, 1);
    chk("c64_addra", ram_addra, 6'h12);
    chk("c64_dina", ram_dina, 32'hA5A5_A5A5);
    chk("c64_enb", ram_enb, 1);
    chk("c64_rd_ready", bus.rd_ready, 1);

    // Arbitration: both held -> 4 refills then 1 invalidate, repeating
    next_cycle();
    bus.rd_en    = 1'b0;
    bus.wr_addr  = 6'h03;
    bus.wr_data  = 32'h11;
    bus.inv_req  = 1'b1;
    bus.inv_addr = 6'h09;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("init_read_valid", bus.rd_valid, 1);
        chk("init_read_data", ram_doutb, 0);
      end
      chk("arb_wr_ack", bus.wr_ack, (i % 5 != 4));
      chk("arb_inv_ack", bus.inv_ack, (i % 5 == 4));
      chk("arb_addra", ram_addra, (i % 5 == 4) ? 6'h09 : 6'h03);
      chk("arb_dina", ram_dina, (i % 5 == 4) ? 32'h0 : 32'h11);
      next_cycle();
    end

    // Write 0xDEADBEEF to 7, read it back
    bus.inv_req = 1'b0;
    bus.wr_addr = 6'h07;
    bus.wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr7_ack", bus.wr_ack, 1);
    chk("wr7_addra", ram_addra, 6'h07);
    chk("wr7_dina", ram_dina, 32'hDEAD_BEEF);
    next_cycle();
    bus.wr_req  = 1'b0;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 6'h07;
    @(negedge clk);
    chk("rd7_enb", ram_enb, 1);
    chk("rd7_addrb", ram_addrb, 6'h07);
    chk("rd7_valid_early", bus.rd_valid, 0);
    next_cycle();
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("rd7_valid", bus.rd_valid, 1);
    chk("rd7_data", ram_doutb, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    chk("rd7_valid_drop", bus.rd_valid, 0);

    // Flush while a refill to 0x05 is held
    next_cycle();
    bus.wr_req    = 1'b1;
    bus.wr_addr   = 6'h05;
    bus.wr_data   = 32'h55;
    bus.flush_req = 1'b1;
    @(negedge clk);
    chk("fl_req_wr_ack", bus.wr_ack, 1);
    chk("fl_req_busy", bus.busy, 0);
    chk("fl_req_addra", ram_addra, 6'h05);
    next_cycle();
    bus.flush_req = 1'b0;
    bus.rd_en     = 1'b1;
    bus.rd_addr   = 6'h05;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      chk("fl_busy", bus.busy, 1);
      chk("fl_addra", ram_addra, c);
      chk("fl_dina", ram_dina, 0);
      chk("fl_wr_ack", bus.wr_ack, 0);
      chk("fl_rd_ready", bus.rd_ready, 0);
      chk("fl_enb", ram_enb, 0);
      chk("fl_rd_valid", bus.rd_valid, 0);
      chk("fl_done_early", bus.flush_done, 0);
      next_cycle();
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("fl_done", bus.flush_done, 1);
    chk("fl_end_busy", bus.busy, 0);
    chk("fl_end_wr_ack", bus.wr_ack, 1);
    chk("fl_end_rd_valid", bus.rd_valid, 0);
    next_cycle();
    bus.wr_req  = 1'b0;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 6'h07;
    @(negedge clk);
    chk("fl_done_pulse", bus.flush_done, 0);
    next_cycle();
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("fl_zero_valid", bus.rd_valid, 1);
    chk("fl_zero_data", ram_doutb, 0);

    // Two flush requests during INIT merge into one sweep
    quiet_inputs();
    resetn = 1'b0;
    repeat (2) next_cycle();
    resetn     = 1'b1;
    busy_cnt   = 0;
    done_cnt   = 0;
    done_at    = -1;
    first_idle = -1;
    for (int c = 0; c < 200; c++) begin
      bus.flush_req = (c == 10 || c == 20);
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (!bus.busy && first_idle < 0) first_idle = c;
      if (bus.flush_done) begin
        done_cnt++;
        done_at = c;
      end
      next_cycle();
    end
    bus.flush_req = 1'b0;
    chk("merge_busy_cycles", busy_cnt, 128);
    chk("merge_first_idle", first_idle, 128);
    chk("merge_done_count", done_cnt, 1);
    chk("merge_done_at", done_at, 128);

    // Reset during a flush at sweep address 30
    bus.flush_req = 1'b1;
    next_cycle();
    bus.flush_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.busy && ram_addra == 6'd30) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
    chk("mid_found_addr30", found, 1);
    resetn = 1'b0;
    next_cycle();
    next_cycle();
    resetn     = 1'b1;
    busy_cnt   = 0;
    done_cnt   = 0;
    first_addr = '1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) first_addr = ram_addra;
      if (bus.busy) busy_cnt++;
      if (bus.flush_done) done_cnt++;
      next_cycle();
    end
    chk("mid_restart_addr", first_addr, 0);
    chk("mid_busy_cycles", busy_cnt, 64);
    chk("mid_no_done", done_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
